// File: rtl/arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for rr_req_arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;
  // Widest requester vector the pick helper is written for.
  localparam int MAX_N        = 16;

  // Index of the first set bit of req at or after ptr, wrapping modulo n.
  // Returns 0 when no bit is set; callers qualify with |req.
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int  sel;
    int  idx;
    logic found;
    sel   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first active request at or after ptr.
module rr_select
  import arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] sel_o,
  output logic                 valid_o
);

  localparam int IDW = $clog2(N);

  logic [MAX_N-1:0] req_ext;

  assign req_ext = MAX_N'(req_i);

  // Pick the winner and flag whether anyone is asking at all.
  always_comb begin
    sel_o   = IDW'(rr_pick(req_ext, int'(ptr_i), N));
    valid_o = |req_i;
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with registered one-hot grant, bounded hold time and
// a one-cycle dead gap between owners.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  MAX_HOLD_C = CW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID    = IDW'(N - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0] sel;
  logic           sel_valid;
  logic [N-1:0]   sel_onehot;
  logic [IDW-1:0] ptr_after_owner;
  logic           owner_req;

  rr_select #(.N(N)) u_rr_select (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .sel_o   (sel),
    .valid_o (sel_valid)
  );

  // One-hot decode of the selected index.
  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel == IDW'(gi));
  end

  // Priority moves to the requester just after the outgoing owner.
  assign ptr_after_owner = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
  assign owner_req       = req[gnt_id_q];

  // Next-state, grant, counter and pointer decisions.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (sel_valid) begin
          gnt_d    = sel_onehot;
          gnt_id_d = sel;
          cnt_d    = CW'(1);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A voluntary release wins over the hold limit in the same cycle.
        if (!owner_req) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          state_d = GAP;
        end else if (cnt_q == MAX_HOLD_C) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          ptr_d     = ptr_after_owner;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset overrides everything, including an active grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_id_q  <= gnt_id_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed scenarios plus random
// request traffic against a behavioural model of owner/gap/pointer.
module tb_rr_req_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: who owns the resource, for how long, and who is next.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  int m_gap   = 0;
  int m_to    = 0;

  logic [N-1:0] prev_gnt = '0;
  int grant_log[$];

  always #5 clk = ~clk;

  rr_req_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else begin errors++; $error("FAIL onehot0: gnt=%b", gnt); end
  a_busy: assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> busy)
    else begin errors++; $error("FAIL gnt_implies_busy: busy=%b gnt=%b", busy, gnt); end
  a_to: assert property (@(posedge clk) disable iff (rst) timeout |-> (gnt == '0))
    else begin errors++; $error("FAIL timeout_no_gnt: gnt=%b", gnt); end
  a_gap: assert property (@(posedge clk) disable iff (rst)
                          ($fell(|gnt) && !$past(rst)) |=> (gnt == '0))
    else begin errors++; $error("FAIL gap_after_fall: gnt=%b", gnt); end

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_gap = 0; m_to = 0;
    end else if (m_owner >= 0) begin
      m_to = 0;
      if (!req[m_owner] || m_hold == MH) begin
        m_to    = req[m_owner] ? 1 : 0;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_hold++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0; m_to = 0;
    end else begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_hold  = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end
  endtask

  // One clock: drive on negedge, update model at posedge, check #1 later.
  task automatic cycle(input logic r, input logic [N-1:0] rq);
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), (m_owner >= 0 || m_gap != 0) ? 32'd1 : 32'd0);
    chk("timeout", 32'(timeout), 32'(m_to));
    if (r) chk("gnt_id_rst", 32'(gnt_id), 32'd0);
    else if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    if (gnt != '0 && prev_gnt == '0) grant_log.push_back(int'(gnt_id));
    prev_gnt = gnt;
    $display("cyc %0d rst=%b req=%b gnt=%b id=%0d busy=%b to=%b",
             cyc, rst, req, gnt, gnt_id, busy, timeout);
  endtask

  initial begin
    logic [N-1:0] rq;

    // Reset held with all requests pending; first grant goes to bit 0.
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);
    chk("p1_rst_gnt", 32'(gnt), 32'd0);
    chk("p1_rst_busy", 32'(busy), 32'd0);
    cycle(1'b0, 4'b1111);
    chk("p1_first", 32'(gnt), 32'b0001);

    // Single requester releases after two cycles.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0100);
    chk("p2_grant", 32'(gnt), 32'b0100);
    cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b0000);
    chk("p2_release", 32'(gnt), 32'd0);
    chk("p2_gap_busy", 32'(busy), 32'd1);
    chk("p2_no_to", 32'(timeout), 32'd0);
    cycle(1'b0, 4'b0000);

    // Hold timeout and re-grant two edges later.
    cycle(1'b1, 4'b0000);
    for (int i = 0; i < MH; i++) cycle(1'b0, 4'b0001);
    chk("p3_held", 32'(gnt), 32'b0001);
    cycle(1'b0, 4'b0001);
    chk("p3_timeout", 32'(timeout), 32'd1);
    chk("p3_revoked", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b0001);
    chk("p3_to_pulse", 32'(timeout), 32'd0);
    cycle(1'b0, 4'b0001);
    chk("p3_regrant", 32'(gnt), 32'b0001);

    // Rotation and wrap with two constant requesters.
    cycle(1'b1, 4'b0000);
    grant_log.delete();
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'b1010);
    chk("p4_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("p4_id0", 32'(grant_log[0]), 32'd1);
      chk("p4_id1", 32'(grant_log[1]), 32'd3);
      chk("p4_id2", 32'(grant_log[2]), 32'd1);
      chk("p4_id3", 32'(grant_log[3]), 32'd3);
    end

    // Reset in the middle of a grant.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b0010);
    chk("p5_mid", 32'(gnt), 32'b0010);
    cycle(1'b1, 4'b0010);
    chk("p5_gnt", 32'(gnt), 32'd0);
    chk("p5_busy", 32'(busy), 32'd0);
    chk("p5_to", 32'(timeout), 32'd0);
    cycle(1'b0, 4'b0011);
    chk("p5_ptr0", 32'(gnt), 32'b0001);

    // Late competitor waits for the owner to release.
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b0101);
    cycle(1'b0, 4'b0101);
    chk("p6_no_preempt", 32'(gnt), 32'b0001);
    cycle(1'b0, 4'b0100);
    chk("p6_release", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b0100);
    chk("p6_gap", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b0100);
    chk("p6_next", 32'(gnt), 32'b0100);

    // Random traffic: sticky requests with occasional toggles and resets.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      cycle(($urandom_range(49) == 0), rq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
